// File: rtl/stack_bus_upstream_arbiter_if.sv
// Upstream channel and stack-bus lane signals for the N-to-1 upstream arbiter.
// master: the side that drives traffic into the channels and sinks the bus lane.
// slave:  the arbiter itself.
interface stack_bus_upstream_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]        ch_valid;
    logic [2*NUM_CH-1:0]      ch_cntl;
    logic [DATA_W*NUM_CH-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     bus_valid;
    logic [1:0]               bus_cntl;
    logic [DATA_W-1:0]        bus_data;
    logic [CH_W-1:0]          bus_chan_id;
    logic                     bus_ready;

    modport master (
        output ch_valid, ch_cntl, ch_data, bus_ready,
        input  ch_ready, bus_valid, bus_cntl, bus_data, bus_chan_id
    );

    modport slave (
        input  ch_valid, ch_cntl, ch_data, bus_ready,
        output ch_ready, bus_valid, bus_cntl, bus_data, bus_chan_id
    );
endinterface

// File: rtl/stack_bus_upstream_arbiter.sv
// Stack-bus upstream merge point: per-channel flit FIFOs feeding one bus lane
// through packet-atomic round-robin arbitration, with framing-error detection
// and a forwarded-packet counter.
module stack_bus_upstream_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       reset_poweron,
    stack_bus_upstream_arbiter_if.slave sb,
    input  logic [NUM_CH-1:0]          cfg_ch_enable,
    output logic [NUM_CH-1:0]          err_framing,
    output logic [15:0]                pkt_count
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FLIT_W = DATA_W + 2;

    localparam logic [1:0] CNTL_EOM = 2'b11;
    localparam logic [1:0] CNTL_SOM = 2'b01;

    typedef enum logic {IDLE, LOCKED} state_t;

    // Per-channel FIFO storage and pointers
    logic [FLIT_W-1:0] mem_q  [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q [NUM_CH];
    logic [PTR_W-1:0]  rptr_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic              rdy_en_q;

    logic [NUM_CH-1:0] ready;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] nonempty;
    logic [1:0]        head_cntl [NUM_CH];
    logic [DATA_W-1:0] head_data [NUM_CH];

    // Arbitration / output path
    state_t            state_q;
    logic [CH_W-1:0]   last_grant_q;
    logic [CH_W-1:0]   cur_ch_q;
    logic              bus_valid_q;
    logic [1:0]        bus_cntl_q;
    logic [DATA_W-1:0] bus_data_q;
    logic [CH_W-1:0]   bus_chan_id_q;
    logic [NUM_CH-1:0] err_q;
    logic [15:0]       pkt_q;

    logic              load;
    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] discard;
    logic [NUM_CH-1:0] err_set;
    logic              gnt_found;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W:0]     rr_sum;
    logic              fwd;
    logic [1:0]        fwd_cntl;
    logic [DATA_W-1:0] fwd_data;
    logic [CH_W-1:0]   fwd_ch;

    // FIFO status, head view, accept decision and next counts
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            nonempty[i]  = (cnt_q[i] != '0);
            ready[i]     = rdy_en_q && (cnt_q[i] != CNT_W'(FIFO_DEPTH));
            push[i]      = sb.ch_valid[i] && ready[i];
            head_cntl[i] = mem_q[i][rptr_q[i]][FLIT_W-1 -: 2];
            head_data[i] = mem_q[i][rptr_q[i]][DATA_W-1:0];
            cnt_d[i]     = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    // Candidate selection, round-robin grant, pops and the flit to forward
    always_comb begin
        load      = !bus_valid_q || sb.bus_ready;
        cand      = '0;
        discard   = '0;
        err_set   = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_sum    = '0;
        fwd       = 1'b0;
        fwd_cntl  = '0;
        fwd_data  = '0;
        fwd_ch    = '0;

        // cntl[1]=1 marks MOM/EOM: a continuation with no open packet is dropped
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_q == IDLE && nonempty[i]) begin
                if (head_cntl[i][1]) begin
                    discard[i] = 1'b1;
                end else if (cfg_ch_enable[i]) begin
                    cand[i] = 1'b1;
                end
            end
        end

        // Search starts just after the last packet owner, wrapping at NUM_CH
        for (int k = 1; k <= NUM_CH; k++) begin
            rr_sum = {1'b0, last_grant_q} + (CH_W+1)'(k);
            if (rr_sum >= (CH_W+1)'(NUM_CH)) begin
                rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
            end
            if (!gnt_found && cand[rr_sum[CH_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_sum[CH_W-1:0];
            end
        end

        pop     = discard;
        err_set = discard;
        if (state_q == IDLE) begin
            if (load && gnt_found) begin
                pop[gnt_idx] = 1'b1;
                fwd          = 1'b1;
                fwd_cntl     = head_cntl[gnt_idx];
                fwd_data     = head_data[gnt_idx];
                fwd_ch       = gnt_idx;
            end
        end else if (load && nonempty[cur_ch_q]) begin
            pop[cur_ch_q] = 1'b1;
            fwd           = 1'b1;
            fwd_data      = head_data[cur_ch_q];
            fwd_ch        = cur_ch_q;
            // A new start inside an open packet closes it as EOM and flags the channel
            if (head_cntl[cur_ch_q][1]) begin
                fwd_cntl = head_cntl[cur_ch_q];
            end else begin
                fwd_cntl          = CNTL_EOM;
                err_set[cur_ch_q] = 1'b1;
            end
        end
    end

    // FIFO data array; contents need no reset since counts gate visibility
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= {sb.ch_cntl[2*i +: 2], sb.ch_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    // FIFO pointers, counts, and the post-reset ready enable
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            rdy_en_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            rdy_en_q <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
                if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Arbiter FSM with registered bus outputs, error flags and packet counter
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q       <= IDLE;
            last_grant_q  <= CH_W'(NUM_CH - 1);
            cur_ch_q      <= '0;
            bus_valid_q   <= 1'b0;
            bus_cntl_q    <= '0;
            bus_data_q    <= '0;
            bus_chan_id_q <= '0;
            err_q         <= '0;
            pkt_q         <= '0;
        end else begin
            if (bus_valid_q && sb.bus_ready && (bus_cntl_q[0] == bus_cntl_q[1])) begin
                pkt_q <= pkt_q + 16'd1;
            end
            if (load) begin
                bus_valid_q <= fwd;
                if (fwd) begin
                    bus_cntl_q    <= fwd_cntl;
                    bus_data_q    <= fwd_data;
                    bus_chan_id_q <= fwd_ch;
                end
            end
            err_q <= err_q | err_set;
            case (state_q)
                IDLE: begin
                    if (fwd) begin
                        last_grant_q <= fwd_ch;
                        cur_ch_q     <= fwd_ch;
                        if (fwd_cntl == CNTL_SOM) state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (fwd && fwd_cntl == CNTL_EOM) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sb.ch_ready    = ready;
    assign sb.bus_valid   = bus_valid_q;
    assign sb.bus_cntl    = bus_cntl_q;
    assign sb.bus_data    = bus_data_q;
    assign sb.bus_chan_id = bus_chan_id_q;
    assign err_framing    = err_q;
    assign pkt_count      = pkt_q;
endmodule

// File: tb/tb_stack_bus_upstream_arbiter.sv
// Scenario bench for stack_bus_upstream_arbiter: expected flits are queued as
// stimulus is issued and matched against flits the bus lane delivers.
`timescale 1ns/1ps
module tb_stack_bus_upstream_arbiter;
    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int CH_W       = 2;

    localparam logic [1:0] C_SE  = 2'b00;
    localparam logic [1:0] C_SOM = 2'b01;
    localparam logic [1:0] C_MOM = 2'b10;
    localparam logic [1:0] C_EOM = 2'b11;

    typedef struct packed {
        logic [1:0]        cntl;
        logic [DATA_W-1:0] data;
        logic [CH_W-1:0]   ch;
        logic [31:0]       cyc;
    } flit_t;

    logic              clk = 1'b0;
    logic              reset_poweron = 1'b0;
    logic [NUM_CH-1:0] cfg_ch_enable;
    logic [NUM_CH-1:0] err_framing;
    logic [15:0]       pkt_count;

    stack_bus_upstream_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) sb ();

    stack_bus_upstream_arbiter #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CH_W(CH_W)
    ) dut (
        .clk          (clk),
        .reset_poweron(reset_poweron),
        .sb           (sb),
        .cfg_ch_enable(cfg_ch_enable),
        .err_framing  (err_framing),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    drv_to   = 0;
    int    obs_rd   = 0;
    logic [NUM_CH-1:0] stall_seen;
    flit_t exp_q[$];
    flit_t obs_q[$];
    flit_t mon_f;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every flit the lane hands over (valid & ready in the middle of the cycle)
    always @(negedge clk) begin
        if (reset_poweron && sb.bus_valid && sb.bus_ready) begin
            mon_f.cntl = sb.bus_cntl;
            mon_f.data = sb.bus_data;
            mon_f.ch   = sb.bus_chan_id;
            mon_f.cyc  = 32'(cyc);
            obs_q.push_back(mon_f);
        end
    end

    task automatic push_exp(input logic [1:0] c, input logic [DATA_W-1:0] d, input int ch);
        flit_t f;
        f.cntl = c;
        f.data = d;
        f.ch   = CH_W'(ch);
        f.cyc  = '0;
        exp_q.push_back(f);
    endtask

    // Hold one flit on a channel until accepted (bounded)
    task automatic drive_flit(input int ch, input logic [1:0] c, input logic [DATA_W-1:0] d);
        bit acc;
        bit done;
        done = 1'b0;
        sb.ch_valid[ch]                 = 1'b1;
        sb.ch_cntl[2*ch +: 2]           = c;
        sb.ch_data[ch*DATA_W +: DATA_W] = d;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            acc = sb.ch_ready[ch];
            if (!acc) stall_seen[ch] = 1'b1;
            @(posedge clk);
            #1;
            done = acc;
        end
        if (!done) drv_to++;
        sb.ch_valid[ch] = 1'b0;
    endtask

    task automatic send_se(input int ch, input int n);
        for (int k = 0; k < n; k++) drive_flit(ch, C_SE, DATA_W'(ch*256 + k));
    endtask

    task automatic send_pkt(input int ch, input int len, input logic [DATA_W-1:0] base);
        for (int k = 0; k < len; k++) begin
            drive_flit(ch, (k == 0) ? C_SOM : ((k == len-1) ? C_EOM : C_MOM), base + DATA_W'(k));
        end
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            if (obs_q.size() - obs_rd >= n) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic do_reset();
        sb.ch_valid   = '0;
        sb.ch_cntl    = '0;
        sb.ch_data    = '0;
        sb.bus_ready  = 1'b1;
        cfg_ch_enable = '1;
        reset_poweron = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_poweron = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        obs_rd     = obs_q.size();
        drv_to     = 0;
        stall_seen = '0;
    endtask

    task automatic test_reset();
        sb.ch_valid   = '0;
        sb.ch_cntl    = '0;
        sb.ch_data    = '0;
        sb.bus_ready  = 1'b1;
        cfg_ch_enable = '1;
        reset_poweron = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.ch_ready !== 4'h0 || sb.bus_valid !== 1'b0 || sb.bus_cntl !== 2'b00) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b valid=%b cntl=%b, required 0000 0 00", sb.ch_ready, sb.bus_valid, sb.bus_cntl);
        end
        checks++;
        if (sb.bus_data !== '0 || sb.bus_chan_id !== '0 || err_framing !== '0 || pkt_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_data: data=%0h id=%0d err=%b pkt=%0d, required all zero", sb.bus_data, sb.bus_chan_id, err_framing, pkt_count);
        end
        @(negedge clk);
        reset_poweron = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sb.ch_ready !== 4'hF || sb.bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready=%b valid=%b, required 1111 0", sb.ch_ready, sb.bus_valid);
        end
    endtask

    task automatic test_single_packet();
        int   start;
        int   base;
        bit   ok;
        flit_t e;
        flit_t o;
        do_reset();
        start = cyc;
        base  = obs_rd;
        push_exp(C_SOM, 64'd1, 0);
        push_exp(C_MOM, 64'd2, 0);
        push_exp(C_EOM, 64'd3, 0);
        drive_flit(0, C_SOM, 64'd1);
        drive_flit(0, C_MOM, 64'd2);
        drive_flit(0, C_EOM, 64'd3);
        wait_obs(3, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_count: got %0d flits, required 3", obs_q.size() - obs_rd); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            checks++;
            if (o.cntl !== e.cntl || o.data !== e.data || o.ch !== e.ch) begin
                failures++;
                $display("FAIL single_flit: got cntl=%b data=%0h ch=%0d, required cntl=%b data=%0h ch=%0d", o.cntl, o.data, o.ch, e.cntl, e.data, e.ch);
            end
        end
        for (int k = 0; k < 3 && base + k < obs_q.size(); k++) begin
            checks++;
            if (int'(obs_q[base+k].cyc) - start !== 2 + k) begin
                failures++;
                $display("FAIL single_latency%0d: got %0d cycles, required %0d", k, int'(obs_q[base+k].cyc) - start, 2 + k);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pkt_count !== 16'd1 || obs_q.size() != obs_rd) begin
            failures++;
            $display("FAIL single_pkt: pkt_count=%0d extra=%0d, required 1 and 0", pkt_count, obs_q.size() - obs_rd);
        end
    endtask

    task automatic test_round_robin();
        int   base;
        bit   ok;
        flit_t e;
        flit_t o;
        do_reset();
        base = obs_rd;
        for (int k = 0; k < 6; k++)
            for (int c = 0; c < NUM_CH; c++) push_exp(C_SE, DATA_W'(c*256 + k), c);
        fork
            send_se(0, 6);
            send_se(1, 6);
            send_se(2, 6);
            send_se(3, 6);
        join
        wait_obs(24, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rr_count: got %0d flits, required 24", obs_q.size() - obs_rd); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            checks++;
            if (o.cntl !== e.cntl || o.data !== e.data || o.ch !== e.ch) begin
                failures++;
                $display("FAIL rr_flit: got cntl=%b data=%0h ch=%0d, required cntl=%b data=%0h ch=%0d", o.cntl, o.data, o.ch, e.cntl, e.data, e.ch);
            end
        end
        if (ok) begin
            checks++;
            if (int'(obs_q[base+23].cyc) - int'(obs_q[base].cyc) !== 23) begin
                failures++;
                $display("FAIL rr_bubbles: 24 flits spanned %0d cycles, required 23", int'(obs_q[base+23].cyc) - int'(obs_q[base].cyc));
            end
        end
        checks++;
        if (stall_seen !== 4'b1111 || drv_to != 0) begin
            failures++;
            $display("FAIL rr_backpressure: stalled channels=%b timeouts=%0d, required 1111 and 0", stall_seen, drv_to);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pkt_count !== 16'd24 || obs_q.size() != obs_rd) begin
            failures++;
            $display("FAIL rr_pkt: pkt_count=%0d extra=%0d, required 24 and 0", pkt_count, obs_q.size() - obs_rd);
        end
    endtask

    task automatic test_no_interleave();
        bit   ok;
        flit_t e;
        flit_t o;
        do_reset();
        push_exp(C_SOM, 64'h100, 1); push_exp(C_MOM, 64'h101, 1);
        push_exp(C_MOM, 64'h102, 1); push_exp(C_EOM, 64'h103, 1);
        push_exp(C_SOM, 64'h200, 2); push_exp(C_MOM, 64'h201, 2);
        push_exp(C_MOM, 64'h202, 2); push_exp(C_EOM, 64'h203, 2);
        fork
            send_pkt(1, 4, 64'h100);
            begin
                @(posedge clk);
                #1;
                send_pkt(2, 4, 64'h200);
            end
        join
        wait_obs(8, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL intlv_count: got %0d flits, required 8", obs_q.size() - obs_rd); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            checks++;
            if (o.cntl !== e.cntl || o.data !== e.data || o.ch !== e.ch) begin
                failures++;
                $display("FAIL intlv_flit: got cntl=%b data=%0h ch=%0d, required cntl=%b data=%0h ch=%0d", o.cntl, o.data, o.ch, e.cntl, e.data, e.ch);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pkt_count !== 16'd2 || err_framing !== 4'b0000 || drv_to != 0) begin
            failures++;
            $display("FAIL intlv_pkt: pkt_count=%0d err=%b timeouts=%0d, required 2 0000 0", pkt_count, err_framing, drv_to);
        end
    endtask

    task automatic test_backpressure();
        bit               ok;
        bit               stable;
        logic             rdy0;
        logic             snap_v;
        logic [1:0]       snap_c;
        logic [DATA_W-1:0] snap_d;
        logic [CH_W-1:0]  snap_i;
        flit_t e;
        flit_t o;
        do_reset();
        for (int k = 0; k < 8; k++)
            push_exp((k == 0) ? C_SOM : ((k == 7) ? C_EOM : C_MOM), 64'hA0 + 64'(k), 0);
        stable = 1'b1;
        rdy0   = 1'b1;
        fork
            send_pkt(0, 8, 64'hA0);
            begin
                wait_obs(2, ok);
                sb.bus_ready = 1'b0;
                snap_v = sb.bus_valid;
                snap_c = sb.bus_cntl;
                snap_d = sb.bus_data;
                snap_i = sb.bus_chan_id;
                repeat (10) begin
                    @(negedge clk);
                    if (sb.bus_valid !== snap_v || sb.bus_cntl !== snap_c ||
                        sb.bus_data !== snap_d || sb.bus_chan_id !== snap_i) stable = 1'b0;
                end
                rdy0 = sb.ch_ready[0];
                @(posedge clk);
                #1;
                sb.bus_ready = 1'b1;
            end
        join
        checks++;
        if (stable !== 1'b1 || snap_v !== 1'b1) begin
            failures++;
            $display("FAIL bp_stable: stable=%b valid=%b, required 1 1", stable, snap_v);
        end
        checks++;
        if (rdy0 !== 1'b0) begin failures++; $display("FAIL bp_ready: ch_ready[0]=%b, required 0", rdy0); end
        wait_obs(8, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_count: got %0d flits, required 8", obs_q.size() - obs_rd); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            checks++;
            if (o.cntl !== e.cntl || o.data !== e.data || o.ch !== e.ch) begin
                failures++;
                $display("FAIL bp_flit: got cntl=%b data=%0h ch=%0d, required cntl=%b data=%0h ch=%0d", o.cntl, o.data, o.ch, e.cntl, e.data, e.ch);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pkt_count !== 16'd1 || obs_q.size() != obs_rd || drv_to != 0) begin
            failures++;
            $display("FAIL bp_pkt: pkt_count=%0d extra=%0d timeouts=%0d, required 1 0 0", pkt_count, obs_q.size() - obs_rd, drv_to);
        end
    endtask

    task automatic test_framing_error();
        bit   ok;
        flit_t e;
        flit_t o;
        do_reset();
        drive_flit(3, C_MOM, 64'h33);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (err_framing !== 4'b1000 || obs_q.size() != obs_rd) begin
            failures++;
            $display("FAIL frm_orphan: err=%b forwarded=%0d, required 1000 and 0", err_framing, obs_q.size() - obs_rd);
        end
        push_exp(C_SOM, 64'h34, 3);
        push_exp(C_EOM, 64'h35, 3);
        push_exp(C_SE,  64'h40, 0);
        drive_flit(3, C_SOM, 64'h34);
        drive_flit(3, C_SOM, 64'h35);
        drive_flit(0, C_SE,  64'h40);
        wait_obs(3, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL frm_count: got %0d flits, required 3", obs_q.size() - obs_rd); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            checks++;
            if (o.cntl !== e.cntl || o.data !== e.data || o.ch !== e.ch) begin
                failures++;
                $display("FAIL frm_flit: got cntl=%b data=%0h ch=%0d, required cntl=%b data=%0h ch=%0d", o.cntl, o.data, o.ch, e.cntl, e.data, e.ch);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err_framing !== 4'b1000 || pkt_count !== 16'd2 || obs_q.size() != obs_rd) begin
            failures++;
            $display("FAIL frm_final: err=%b pkt=%0d extra=%0d, required 1000 2 0", err_framing, pkt_count, obs_q.size() - obs_rd);
        end
    endtask

    task automatic test_reset_mid_packet();
        bit   ok;
        flit_t e;
        flit_t o;
        do_reset();
        drive_flit(0, C_SOM, 64'h50);
        drive_flit(0, C_MOM, 64'h51);
        wait_obs(1, ok);
        #2;
        reset_poweron = 1'b0;
        #1;
        checks++;
        if (sb.bus_valid !== 1'b0 || sb.bus_cntl !== 2'b00 || sb.bus_data !== '0 || sb.bus_chan_id !== '0) begin
            failures++;
            $display("FAIL midrst_bus: valid=%b cntl=%b data=%0h id=%0d, required all zero", sb.bus_valid, sb.bus_cntl, sb.bus_data, sb.bus_chan_id);
        end
        checks++;
        if (sb.ch_ready !== 4'h0 || pkt_count !== 16'd0 || err_framing !== '0) begin
            failures++;
            $display("FAIL midrst_ctrl: ready=%b pkt=%0d err=%b, required 0000 0 0000", sb.ch_ready, pkt_count, err_framing);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_poweron = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        obs_rd     = obs_q.size();
        stall_seen = '0;
        drv_to     = 0;
        push_exp(C_SE, 64'h60, 1);
        drive_flit(1, C_SE, 64'h60);
        wait_obs(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL midrst_count: got %0d flits, required 1", obs_q.size() - obs_rd); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            checks++;
            if (o.cntl !== e.cntl || o.data !== e.data || o.ch !== e.ch) begin
                failures++;
                $display("FAIL midrst_flit: got cntl=%b data=%0h ch=%0d, required cntl=%b data=%0h ch=%0d", o.cntl, o.data, o.ch, e.cntl, e.data, e.ch);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pkt_count !== 16'd1 || obs_q.size() != obs_rd || stall_seen[1] !== 1'b0) begin
            failures++;
            $display("FAIL midrst_pkt: pkt=%0d extra=%0d stalled=%b, required 1 0 0", pkt_count, obs_q.size() - obs_rd, stall_seen[1]);
        end
    endtask

    initial begin
        sb.ch_valid   = '0;
        sb.ch_cntl    = '0;
        sb.ch_data    = '0;
        sb.bus_ready  = 1'b1;
        cfg_ch_enable = '1;
        stall_seen    = '0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_no_interleave();
        test_backpressure();
        test_framing_error();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
